cpu_debug_cmd_dispatch: RTL and testbench
=========================================

Name: cpu_debug_cmd_dispatch

Overview:
- Next-generation system-clock half of the CPU JTAG debug slave.
- Takes the update strobes and the shift register from the TCK-side logic and synchronises them into the clk domain.
- Queues captured debug commands in a small FIFO and hands them to the debug core with a valid/ready handshake.
- Emits one-hot take_action / take_no_action pulses per IR code.
- Generalises the fixed 38-bit / 2-bit-IR / single-entry version in four ways: parametrised widths, parametrised synchroniser depth, buffering, and overflow reporting.

Parameters:
- SR_W, 38: shift-register / jdo width.
- IR_W, 2: virtual IR width; the number of action channels is 2**IR_W.
- SYNC_STAGES, 2: synchroniser flops on vs_udr and vs_uir (minimum 2).
- DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- ACTION_BIT, 34: sr bit index that selects action (1) or no-action (0).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_in  in  IR_W  virtual IR value from the TCK side; stable whenever vs_uir is high.
- sr  in  SR_W  TCK-side shift register; stable from vs_udr rise until the next shift.
- vs_udr  in  1  virtual update-DR, asynchronous to clk.
- vs_uir  in  1  virtual update-IR, asynchronous to clk.
- cmd_ready  in  1  consumer accepts the head command.
- cmd_valid  out  1  FIFO not empty.
- cmd_ir  out  IR_W  IR of the head entry.
- jdo  out  SR_W  sr of the most recently popped command.
- take_action  out  2**IR_W  one-cycle one-hot pulse, bit = popped IR.
- take_no_action  out  2**IR_W  one-cycle one-hot pulse, bit = popped IR.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky: a command was dropped.

Behaviour:
- Reset values: all outputs 0, synchronisers 0, ir_lat 0, FIFO empty.
- Reset is asynchronous on assert and takes effect immediately mid-operation. Queued commands are discarded; no pulse is emitted.
- Synchronisation:
  - vs_udr and vs_uir each pass through SYNC_STAGES flops, then one edge-detect flop.
  - A rise is a single-cycle event (udr_rise, uir_rise).
  - A level held high produces exactly one rise.
- uir_rise:
  - ir_lat <= ir_in.
  - overflow <= 0.
- udr_rise:
  - Pushes {ir_lat, sr} into the FIFO.
  - If uir_rise occurs in the same cycle, the new ir_in value is pushed, not the old ir_lat.
- Latency: with vs_udr sampled high at edge k and the FIFO empty, cmd_valid = 1 after edge k+SYNC_STAGES+1.
- Handshake:
  - A pop occurs on a clk edge with cmd_valid && cmd_ready.
  - cmd_ready while empty is ignored.
  - cmd_valid and cmd_ir never change while cmd_valid=1 && cmd_ready=0.
- Pop response, in the cycle after the pop edge:
  - jdo = popped sr.
  - If popped sr[ACTION_BIT]=1: take_action[popped ir] = 1. Otherwise take_no_action[popped ir] = 1.
  - Exactly one bit across both vectors is high, for exactly one cycle. Both vectors are otherwise 0.
  - jdo holds its value until the next pop.
- Push and pop in the same cycle:
  - Both occur; level is unchanged.
  - When level == DEPTH, the pop frees a slot and the push is accepted.
- Full: a udr_rise with level == DEPTH and no pop in that cycle drops the command and sets overflow=1. FIFO contents are unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is maintained as a separate counter, 0..DEPTH.
- Back-to-back pops pulse on consecutive cycles, one pulse per pop.

Test Plan:
- Single command: reset, pulse vs_uir with ir_in=2'b01, then pulse vs_udr with sr=38'h04_0000_1234 (bit34=1), cmd_ready=1 -> cmd_valid rises 3 edges after vs_udr is sampled; the next cycle shows take_action=4'b0010 for 1 cycle, take_no_action=0, jdo=38'h04_0000_1234.
- No-action path: ir_in=2'b11, sr=38'h00_DEAD_BEEF -> take_no_action=4'b1000 one cycle, take_action=0.
- Buffering/backpressure: cmd_ready=0, push 4 commands with sr=1,2,3,4 -> level=4, cmd_valid=1, no pulses. Raise cmd_ready -> four pulses on consecutive cycles, jdo=1,2,3,4 in order, level ends at 0.
- Overflow: with the FIFO full and cmd_ready=0, a 5th udr -> dropped, overflow=1, level=4. Drain all -> contents are 1..4. A uir pulse -> overflow=0.
- Long strobe / simultaneous events: vs_udr held high for 20 cycles -> exactly one push. Inject uir_rise and udr_rise on the same synchronised cycle with ir_in=2'b10 -> pushed cmd_ir=2'b10. Push at level=4 together with a pop -> accepted, overflow stays 0.
- Reset mid-operation: assert reset_n=0 with level=3 -> cmd_valid, level, jdo, take_action and take_no_action are all 0 immediately. No pulses after release. A fresh command then behaves as in the single-command scenario.

Source files
------------

// File: rtl/cpu_debug_cmd_dispatch.sv
// System-clock half of the CPU JTAG debug slave: synchronises the TCK-side update strobes,
// queues captured commands in a small FIFO and issues one-hot action pulses on each pop.
module cpu_debug_cmd_dispatch #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int ACTION_BIT  = 34
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [IR_W-1:0]              ir_in,
    input  logic [SR_W-1:0]              sr,
    input  logic                         vs_udr,
    input  logic                         vs_uir,
    input  logic                         cmd_ready,
    output logic                         cmd_valid,
    output logic [IR_W-1:0]              cmd_ir,
    output logic [SR_W-1:0]              jdo,
    output logic [2**IR_W-1:0]           take_action,
    output logic [2**IR_W-1:0]           take_no_action,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int NCH = 2**IR_W;
    localparam int LW  = $clog2(DEPTH+1);
    localparam int PW  = $clog2(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_prev, uir_prev;
    logic                   udr_rise, uir_rise;
    logic [IR_W-1:0]        ir_lat;

    logic [SR_W-1:0]        sr_mem [DEPTH];
    logic [IR_W-1:0]        ir_mem [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;

    logic                   pop, push, full;
    logic [IR_W-1:0]        push_ir;
    logic [NCH-1:0]         head_onehot;

    // Rise flags are registered so each strobe gives exactly one single-cycle event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_prev <= 1'b0;
            uir_prev <= 1'b0;
            udr_rise <= 1'b0;
            uir_rise <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_prev <= udr_sync[SYNC_STAGES-1];
            uir_prev <= uir_sync[SYNC_STAGES-1];
            udr_rise <= udr_sync[SYNC_STAGES-1] & ~udr_prev;
            uir_rise <= uir_sync[SYNC_STAGES-1] & ~uir_prev;
        end
    end

    assign cmd_valid = (level != '0);
    assign cmd_ir    = cmd_valid ? ir_mem[rd_ptr] : '0;
    assign full      = (level == LVL_FULL);
    assign pop       = cmd_valid & cmd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push      = udr_rise & (~full | pop);
    assign push_ir   = uir_rise ? ir_in : ir_lat;

    always_comb begin
        head_onehot         = '0;
        head_onehot[cmd_ir] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sr_mem[wr_ptr] <= sr;
            ir_mem[wr_ptr] <= push_ir;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_lat         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            overflow       <= 1'b0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (uir_rise) begin
                ir_lat   <= ir_in;
                overflow <= 1'b0;
            end
            if (udr_rise && full && !pop)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                jdo    <= sr_mem[rd_ptr];
                if (sr_mem[rd_ptr][ACTION_BIT])
                    take_action <= head_onehot;
                else
                    take_no_action <= head_onehot;
            end
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_debug_cmd_dispatch.sv
// Self-checking bench for cpu_debug_cmd_dispatch: a queue-based command model predicts
// FIFO contents, occupancy, overflow and the pop-response pulses.
module tb_cpu_debug_cmd_dispatch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr, vs_uir, cmd_ready;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic [2:0]  level;
    logic        overflow;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
    } cmd_t;

    cmd_t        mq[$];
    logic [1:0]  ir_lat_m;
    logic        ovf_m;
    logic [37:0] jdo_m;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    cpu_debug_cmd_dispatch #(
        .SR_W(38), .IR_W(2), .SYNC_STAGES(2), .DEPTH(4), .ACTION_BIT(34)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] ir);
        logic [3:0] one;
        one = 4'b0001;
        return one << ir;
    endfunction

    task automatic do_uir(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(); tick();
        vs_uir = 1'b0;
        repeat (4) tick();
        ir_lat_m = ir;
        ovf_m    = 1'b0;
        n_total++;
        if (overflow !== ovf_m) $display("FAIL uir_overflow: got %0b want %0b", overflow, ovf_m);
        else n_pass++;
    endtask

    task automatic do_udr(input logic [37:0] srv);
        logic [1:0] head_ir;
        sr     = srv;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        repeat (4) tick();
        if (mq.size() < 4) mq.push_back('{ir: ir_lat_m, sr: srv});
        else ovf_m = 1'b1;
        head_ir = (mq.size() != 0) ? mq[0].ir : 2'b00;
        n_total++;
        if (level !== 3'(mq.size())) $display("FAIL push_level: got %0d want %0d", level, mq.size());
        else n_pass++;
        n_total++;
        if (cmd_valid !== (mq.size() != 0)) $display("FAIL push_valid: got %0b want %0b", cmd_valid, mq.size() != 0);
        else n_pass++;
        n_total++;
        if (cmd_ir !== head_ir) $display("FAIL push_cmd_ir: got %0b want %0b", cmd_ir, head_ir);
        else n_pass++;
        n_total++;
        if (overflow !== ovf_m) $display("FAIL push_overflow: got %0b want %0b", overflow, ovf_m);
        else n_pass++;
        n_total++;
        if ({take_action, take_no_action} !== 8'h00)
            $display("FAIL push_no_pulse: got act=%b noact=%b want 0", take_action, take_no_action);
        else n_pass++;
    endtask

    task automatic drain(input int n);
        cmd_t c;
        logic [3:0] exp_a, exp_n;
        cmd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            n_total++;
            if (cmd_valid !== 1'b1 || cmd_ir !== mq[0].ir)
                $display("FAIL drain_head: got valid=%0b ir=%0b want valid=1 ir=%0b", cmd_valid, cmd_ir, mq[0].ir);
            else n_pass++;
            tick();
            c     = mq.pop_front();
            jdo_m = c.sr;
            exp_a = c.sr[34] ? onehot(c.ir) : 4'b0000;
            exp_n = c.sr[34] ? 4'b0000 : onehot(c.ir);
            n_total++;
            if (jdo !== jdo_m) $display("FAIL drain_jdo: got %h want %h", jdo, jdo_m);
            else n_pass++;
            n_total++;
            if (take_action !== exp_a || take_no_action !== exp_n)
                $display("FAIL drain_pulse: got act=%b noact=%b want act=%b noact=%b",
                         take_action, take_no_action, exp_a, exp_n);
            else n_pass++;
            n_total++;
            if (level !== 3'(mq.size())) $display("FAIL drain_level: got %0d want %0d", level, mq.size());
            else n_pass++;
        end
        cmd_ready = 1'b0;
        tick();
        n_total++;
        if ({take_action, take_no_action} !== 8'h00 || jdo !== jdo_m)
            $display("FAIL drain_idle: got act=%b noact=%b jdo=%h want 0 0 %h",
                     take_action, take_no_action, jdo, jdo_m);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_total++;
        if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, level, overflow} !== '0)
            $display("FAIL reset_outputs: got valid=%0b ir=%0b jdo=%h act=%b noact=%b level=%0d ovf=%0b want all 0",
                     cmd_valid, cmd_ir, jdo, take_action, take_no_action, level, overflow);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [37:0] v;
        v = 38'h04_0000_1234;
        do_uir(2'b01);
        cmd_ready = 1'b1;
        sr        = v;
        vs_udr    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vs_udr = 1'b0;
            n_total++;
            if (cmd_valid !== 1'b0) $display("FAIL single_latency_early: edge %0d got valid=%0b want 0", i, cmd_valid);
            else n_pass++;
        end
        tick();
        n_total++;
        if (cmd_valid !== 1'b1 || cmd_ir !== 2'b01)
            $display("FAIL single_latency: got valid=%0b ir=%0b want valid=1 ir=01", cmd_valid, cmd_ir);
        else n_pass++;
        tick();
        n_total++;
        if (take_action !== 4'b0010 || take_no_action !== 4'b0000 || jdo !== v || level !== 3'd0)
            $display("FAIL single_pulse: got act=%b noact=%b jdo=%h level=%0d want 0010 0000 %h 0",
                     take_action, take_no_action, jdo, level, v);
        else n_pass++;
        tick();
        cmd_ready = 1'b0;
        n_total++;
        if ({take_action, take_no_action} !== 8'h00 || jdo !== v)
            $display("FAIL single_one_cycle: got act=%b noact=%b jdo=%h want 0 0 %h", take_action, take_no_action, jdo, v);
        else n_pass++;
        jdo_m = v;
    endtask

    task automatic test_no_action();
        do_uir(2'b11);
        do_udr(38'h00_DEAD_BEEF);
        drain(1);
    endtask

    task automatic test_backpressure();
        do_uir(2'b00);
        for (int i = 1; i <= 4; i++) do_udr(38'(i));
        drain(4);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) do_udr(38'(i) | 38'h04_0000_0000);
        do_udr(38'h3F_FFFF_FFFF);
        drain(4);
        do_uir(2'b10);
    endtask

    task automatic test_random();
        logic [63:0] r;
        int n;
        for (int round = 0; round < 6; round++) begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 1) == 1) do_uir(2'($urandom_range(0, 3)));
                r = {$urandom, $urandom};
                do_udr(r[37:0]);
            end
            drain(mq.size());
        end
    endtask

    task automatic test_long_strobe();
        sr     = 38'h04_1111_2222;
        vs_udr = 1'b1;
        repeat (20) tick();
        vs_udr = 1'b0;
        repeat (4) tick();
        mq.push_back('{ir: ir_lat_m, sr: sr});
        n_total++;
        if (level !== 3'd1) $display("FAIL long_strobe_level: got %0d want 1", level);
        else n_pass++;
        drain(1);
    endtask

    task automatic test_simultaneous();
        do_uir(2'b01);
        ir_in  = 2'b10;
        sr     = 38'h00_0000_5A5A;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        tick(); tick();
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (4) tick();
        ir_lat_m = 2'b10;
        ovf_m    = 1'b0;
        mq.push_back('{ir: 2'b10, sr: sr});
        n_total++;
        if (cmd_valid !== 1'b1 || cmd_ir !== 2'b10 || level !== 3'd1)
            $display("FAIL simul_cmd_ir: got valid=%0b ir=%0b level=%0d want 1 10 1", cmd_valid, cmd_ir, level);
        else n_pass++;
        drain(1);
    endtask

    task automatic test_push_pop_full();
        cmd_t c;
        for (int i = 0; i < 4; i++) do_udr(38'(16 + i));
        sr     = 38'h04_0000_0099;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick(); tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        c     = mq.pop_front();
        jdo_m = c.sr;
        mq.push_back('{ir: ir_lat_m, sr: sr});
        n_total++;
        if (jdo !== c.sr || take_no_action !== onehot(c.ir) || take_action !== 4'b0000)
            $display("FAIL full_pushpop_pulse: got jdo=%h act=%b noact=%b want %h 0000 %b",
                     jdo, take_action, take_no_action, c.sr, onehot(c.ir));
        else n_pass++;
        tick();
        n_total++;
        if (level !== 3'd4 || overflow !== 1'b0)
            $display("FAIL full_pushpop_level: got level=%0d ovf=%0b want 4 0", level, overflow);
        else n_pass++;
        drain(4);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) do_udr(38'h04_0000_0A00 + 38'(i));
        drain(1);
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, level, overflow} !== '0)
            $display("FAIL reset_mid_outputs: got valid=%0b level=%0d jdo=%h act=%b noact=%b want all 0",
                     cmd_valid, level, jdo, take_action, take_no_action);
        else n_pass++;
        mq.delete();
        ir_lat_m = 2'b00;
        ovf_m    = 1'b0;
        jdo_m    = '0;
        tick(); tick();
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({take_action, take_no_action} !== 8'h00 || level !== 3'd0 || cmd_valid !== 1'b0)
                $display("FAIL reset_mid_quiet: got act=%b noact=%b level=%0d valid=%0b want 0",
                         take_action, take_no_action, level, cmd_valid);
            else n_pass++;
        end
        cmd_ready = 1'b0;
        test_single();
    endtask

    initial begin
        reset_n   = 1'b0;
        ir_in     = '0;
        sr        = '0;
        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        cmd_ready = 1'b0;
        ir_lat_m  = '0;
        ovf_m     = 1'b0;
        jdo_m     = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_no_action();
        test_backpressure();
        test_overflow();
        test_random();
        test_long_strobe();
        test_simultaneous();
        test_push_pop_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
